quarter_engine: RTL and testbench

- Self-sequencing ChaCha column engine: holds one column (a, b, c, d) of the 4x4 state.
- Runs a selectable number of rounds autonomously after `start`, including the diagonal word rotation and the final add-back.
- Four instances with `col`=0..3 are chained ring-wise through shift_in/shift_out to form a block core.
- Generalises the previous column unit in three ways: word width, rotation amounts, and round count are configurable; it has a start/busy/done handshake, abort, and a single-quarter-round test mode.

---
 rtl/chacha_pkg.sv | 41 ++++
 rtl/quarter_alu.sv | 45 ++++
 rtl/quarter_engine.sv | 171 +++++++++++++++++
 tb/tb_quarter_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha column engine: FSM states, round-count
// encoding, default rotations, address field layout and ring-rotation select tables.
package chacha_pkg;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ROT, S_ADD, S_DONE} state_e;

  typedef enum logic [1:0] {RS_8 = 2'd0, RS_12 = 2'd1, RS_20 = 2'd2, RS_TEST = 2'd3} rounds_sel_e;

  typedef enum logic [1:0] {W_A, W_B, W_C, W_D} word_sel_e;

  localparam int ROT0_DEF = 16;
  localparam int ROT1_DEF = 12;
  localparam int ROT2_DEF = 8;
  localparam int ROT3_DEF = 7;

  localparam int ADDR_COL_W = 2;
  localparam int ADDR_ROW_W = 2;

  function automatic int addr_col_lsb(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int addr_row_lsb(input int word_w);
    return $clog2(word_w / 8) + ADDR_COL_W;
  endfunction

  // b moves 1 column, c 2, d 3 after a column round; the odd table completes each to 4
  localparam int ROT_PHASES = 6;
  localparam word_sel_e ROT_SEL_EVEN [ROT_PHASES] = '{W_B, W_C, W_C, W_D, W_D, W_D};
  localparam word_sel_e ROT_SEL_ODD  [ROT_PHASES] = '{W_B, W_B, W_B, W_C, W_C, W_D};

  function automatic logic [4:0] round_count(input rounds_sel_e sel);
    case (sel)
      RS_8:    return 5'd8;
      RS_12:   return 5'd12;
      RS_20:   return 5'd20;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/quarter_alu.sv
// Combinational ChaCha quarter-round step: one add/xor/rotate per step index.
module quarter_alu
  import chacha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROT0   = ROT0_DEF,
  parameter int ROT1   = ROT1_DEF,
  parameter int ROT2   = ROT2_DEF,
  parameter int ROT3   = ROT3_DEF
) (
  input  logic [1:0]        step,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] a_nxt,
  output logic [WORD_W-1:0] b_nxt,
  output logic [WORD_W-1:0] c_nxt,
  output logic [WORD_W-1:0] d_nxt
);

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  logic [WORD_W-1:0] ab;
  logic [WORD_W-1:0] cd;

  assign ab = a + b;
  assign cd = c + d;

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    c_nxt = c;
    d_nxt = d;
    case (step)
      2'd0: begin a_nxt = ab; d_nxt = rotl(d ^ ab, ROT0); end
      2'd1: begin c_nxt = cd; b_nxt = rotl(b ^ cd, ROT1); end
      2'd2: begin a_nxt = ab; d_nxt = rotl(d ^ ab, ROT2); end
      default: begin c_nxt = cd; b_nxt = rotl(b ^ cd, ROT3); end
    endcase
  end

endmodule

// File: rtl/quarter_engine.sv
// One ChaCha column (a, b, c, d) with its own round sequencer; four instances chained
// through shift_in/shift_out form a complete block core.
//
// state  | meaning
// IDLE   | accepts byte writes and start
// CALC   | quarter-round step 0..3, one per cycle
// ROT    | phase 0..5, ring-shifts b/c/d between column and diagonal layout
// ADD    | every word += its init copy
// DONE   | one-cycle completion pulse
module quarter_engine
  import chacha_pkg::*;
#(
  parameter int              WORD_W = 32,
  parameter int              COL    = 0,
  parameter logic [WORD_W-1:0] A_INIT = '0,
  parameter int              ROT0   = ROT0_DEF,
  parameter int              ROT1   = ROT1_DEF,
  parameter int              ROT2   = ROT2_DEF,
  parameter int              ROT3   = ROT3_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               write,
  input  logic [3+$clog2(WORD_W/8):0]        addr,
  input  logic [7:0]                         data_in,
  output logic [7:0]                         data_out,
  input  logic                               start,
  input  logic [1:0]                         rounds_sel,
  input  logic                               abort,
  output logic                               busy,
  output logic                               done,
  input  logic [WORD_W-1:0]                  shift_in,
  output logic [WORD_W-1:0]                  shift_out
);

  localparam int BAW     = $clog2(WORD_W / 8);
  localparam int NB      = WORD_W / 8;
  localparam int COL_LSB = addr_col_lsb(WORD_W);
  localparam int ROW_LSB = addr_row_lsb(WORD_W);

  state_e            state, state_nxt;
  rounds_sel_e       rsel_q;
  logic [1:0]        step;
  logic [2:0]        phase;
  logic [4:0]        rnd_cnt;
  logic [WORD_W-1:0] a, b, c, d;
  logic [WORD_W-1:0] a_init, b_init, c_init, d_init;
  logic [WORD_W-1:0] a_alu, b_alu, c_alu, d_alu;
  logic [WORD_W-1:0] rd_word;
  logic [BAW-1:0]    byte_idx;
  logic [1:0]        col_idx, row_idx;
  logic              col_hit, last_step, last_phase, more_rounds;
  word_sel_e         rot_sel;

  assign byte_idx = addr[BAW-1:0];
  assign col_idx  = addr[COL_LSB +: ADDR_COL_W];
  assign row_idx  = addr[ROW_LSB +: ADDR_ROW_W];
  assign col_hit  = (col_idx == COL[1:0]);

  assign last_step   = (step == 2'd3);
  assign last_phase  = (phase == 3'(ROT_PHASES - 1));
  assign more_rounds = (rnd_cnt + 5'd1) < round_count(rsel_q);

  quarter_alu #(
    .WORD_W(WORD_W), .ROT0(ROT0), .ROT1(ROT1), .ROT2(ROT2), .ROT3(ROT3)
  ) u_alu (
    .step(step), .a(a), .b(b), .c(c), .d(d),
    .a_nxt(a_alu), .b_nxt(b_alu), .c_nxt(c_alu), .d_nxt(d_alu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_CALC;
        S_CALC: if (last_step) state_nxt = (rsel_q == RS_TEST) ? S_DONE : S_ROT;
        S_ROT:  if (last_phase) state_nxt = more_rounds ? S_CALC : S_ADD;
        S_ADD:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    rot_sel   = rnd_cnt[0] ? ROT_SEL_ODD[phase] : ROT_SEL_EVEN[phase];
    shift_out = '0;
    if (state == S_ROT) begin
      case (rot_sel)
        W_A:     shift_out = a;
        W_B:     shift_out = b;
        W_C:     shift_out = c;
        default: shift_out = d;
      endcase
    end
  end

  always_comb begin
    case (row_idx)
      2'd0:    rd_word = a;
      2'd1:    rd_word = b;
      2'd2:    rd_word = c;
      default: rd_word = d;
    endcase
    data_out = '0;
    for (int i = 0; i < NB; i++)
      if (col_hit && byte_idx == BAW'(i)) data_out = rd_word[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= A_INIT; b <= '0; c <= '0; d <= '0;
      a_init <= A_INIT; b_init <= '0; c_init <= '0; d_init <= '0;
      step <= '0; phase <= '0; rnd_cnt <= '0; rsel_q <= RS_8;
    end else if (abort) begin
      a <= a_init; b <= b_init; c <= c_init; d <= d_init;
    end else begin
      case (state)
        S_IDLE: begin
          // a write in the start cycle lands before the first CALC reads the words
          if (write && col_hit) begin
            for (int i = 0; i < NB; i++) begin
              if (byte_idx == BAW'(i)) begin
                case (row_idx)
                  2'd0: begin a[8*i +: 8] <= data_in; a_init[8*i +: 8] <= data_in; end
                  2'd1: begin b[8*i +: 8] <= data_in; b_init[8*i +: 8] <= data_in; end
                  2'd2: begin c[8*i +: 8] <= data_in; c_init[8*i +: 8] <= data_in; end
                  default: begin d[8*i +: 8] <= data_in; d_init[8*i +: 8] <= data_in; end
                endcase
              end
            end
          end
          if (start) begin
            rnd_cnt <= '0;
            step    <= '0;
            phase   <= '0;
            rsel_q  <= rounds_sel_e'(rounds_sel);
          end
        end
        S_CALC: begin
          a <= a_alu; b <= b_alu; c <= c_alu; d <= d_alu;
          step  <= step + 2'd1;
          phase <= '0;
        end
        S_ROT: begin
          case (rot_sel)
            W_A:     a <= shift_in;
            W_B:     b <= shift_in;
            W_C:     c <= shift_in;
            default: d <= shift_in;
          endcase
          phase <= phase + 3'd1;
          if (last_phase) rnd_cnt <= rnd_cnt + 5'd1;
        end
        S_ADD: begin
          a <= a + a_init; b <= b + b_init; c <= c + c_init; d <= d + d_init;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quarter_engine.sv
// Four chained engines forming a ChaCha block core, checked by a scoreboard against
// RFC 8439 vectors and a straightforward block-function model.
module tb_quarter_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  addr = '0;
  logic [7:0]  data_in = '0;
  logic        start = 1'b0;
  logic [1:0]  rounds_sel = '0;
  logic        abort = 1'b0;
  logic [3:0]  busy_v, done_v;
  logic [7:0]  dout [4];
  logic [31:0] sh [4];
  logic        busy, done;
  logic [7:0]  data_out;

  localparam logic [31:0] AI [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  assign busy     = |busy_v;
  assign done     = |done_v;
  assign data_out = dout[0] | dout[1] | dout[2] | dout[3];

  for (genvar k = 0; k < 4; k++) begin : g_col
    quarter_engine #(.WORD_W(32), .COL(k), .A_INIT(AI[k])) u_eng (
      .clk(clk), .rst(rst), .write(write), .addr(addr), .data_in(data_in),
      .data_out(dout[k]), .start(start), .rounds_sel(rounds_sel), .abort(abort),
      .busy(busy_v[k]), .done(done_v[k]),
      .shift_in(sh[(k+1)%4]), .shift_out(sh[k])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         stat;
    logic [7:0] exp;
  } item_t;

  item_t chk_q[$];
  int    done_q[$];
  logic  chk = 1'b0;
  int    cyc = 0, start_cyc = 0, busy_run = 0;
  int    total = 0, bad = 0;

  logic [31:0] st [16];
  logic [31:0] ex [16];
  logic [31:0] m  [16];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: done pulses and scheduled reads are compared against queued expectations
  always @(negedge clk) begin
    if (busy) busy_run = busy_run + 1;
    else      busy_run = 0;
    if (done) begin
      if (done_q.size() == 0) fail("unexpected_done");
      else begin
        int e;
        e = done_q.pop_front();
        check("done_cycle", cyc - start_cyc, e);
        check("busy_span", busy_run, e + 1);
      end
    end
    if (chk) begin
      if (chk_q.size() == 0) fail("scoreboard_underflow");
      else begin
        item_t it;
        it = chk_q.pop_front();
        check(it.name, it.stat ? {30'b0, busy, done} : {24'b0, data_out}, {24'b0, it.exp});
      end
    end
  end

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic qr(input int a, input int b, input int c, input int d);
    m[a] = m[a] + m[b]; m[d] = rl(m[d] ^ m[a], 16);
    m[c] = m[c] + m[d]; m[b] = rl(m[b] ^ m[c], 12);
    m[a] = m[a] + m[b]; m[d] = rl(m[d] ^ m[a], 8);
    m[c] = m[c] + m[d]; m[b] = rl(m[b] ^ m[c], 7);
  endtask

  task automatic model(input int nr);
    m = st;
    for (int r = 0; r < nr; r += 2) begin
      qr(0, 4, 8, 12); qr(1, 5, 9, 13); qr(2, 6, 10, 14); qr(3, 7, 11, 15);
      qr(0, 5, 10, 15); qr(1, 6, 11, 12); qr(2, 7, 8, 13); qr(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) ex[i] = m[i] + st[i];
  endtask

  task automatic set_rfc();
    for (int i = 0; i < 4; i++) st[i] = AI[i];
    for (int i = 0; i < 8; i++) st[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    st[12] = 32'h00000001;
    st[13] = 32'h09000000;
    st[14] = 32'h4a000000;
    st[15] = 32'h00000000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input int idx, input int bi, input logic [7:0] v);
    write = 1'b1;
    addr = {2'(idx / 4), 2'(idx % 4), 2'(bi)};
    data_in = v;
    tick();
    write = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < 16; i++)
      for (int bi = 0; bi < 4; bi++) begin
        logic [31:0] w;
        w = st[i];
        wr_byte(i, bi, w[8*bi +: 8]);
      end
  endtask

  task automatic rd_word(input int idx, input logic [31:0] exp, input string nm);
    item_t it;
    for (int bi = 0; bi < 4; bi++) begin
      addr = {2'(idx / 4), 2'(idx % 4), 2'(bi)};
      it.name = $sformatf("%s.b%0d", nm, bi);
      it.stat = 1'b0;
      it.exp  = exp[8*bi +: 8];
      chk_q.push_back(it);
      chk = 1'b1;
      @(negedge clk);
      #1;
      chk = 1'b0;
    end
  endtask

  task automatic rd_all(input string nm);
    for (int i = 0; i < 16; i++) rd_word(i, ex[i], $sformatf("%s_w%0d", nm, i));
  endtask

  task automatic chk_stat(input string nm, input logic b, input logic d);
    item_t it;
    it.name = nm;
    it.stat = 1'b1;
    it.exp  = {6'b0, b, d};
    chk_q.push_back(it);
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic go(input logic [1:0] rs, input int exp_done, input bit expect_done);
    if (expect_done) done_q.push_back(exp_done);
    rounds_sel = rs;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int limit, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail({nm, "_done_timeout"});
      done_q.delete();
    end
    tick();
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_stat("reset_status", 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // single quarter round, RFC 8439 2.1.1, in column 0
    for (int i = 0; i < 16; i++) st[i] = '0;
    st[0] = 32'h11111111; st[4] = 32'h01020304; st[8] = 32'h9b8d6f43; st[12] = 32'h01234567;
    load();
    go(2'd3, 4, 1'b1);
    wait_done(20, "test_mode");
    rd_word(0,  32'hea2a92f4, "tm_a");
    rd_word(4,  32'hcb1cf8ce, "tm_b");
    rd_word(8,  32'h4581472e, "tm_c");
    rd_word(12, 32'h5881c4bb, "tm_d");

    // full 20-round block, RFC 8439 2.3.2
    set_rfc();
    load();
    model(20);
    go(2'd2, 201, 1'b1);
    wait_done(260, "r20");
    rd_word(0,  32'he4e7f110, "rfc_w0");
    rd_word(5,  32'h0368c033, "rfc_w5");
    rd_word(15, 32'h4e3c50a2, "rfc_w15");
    rd_all("r20");

    // 8 rounds; write, rounds_sel change and second start while busy are ignored
    load();
    model(8);
    go(2'd0, 81, 1'b1);
    repeat (19) tick();
    wr_byte(11, 1, 8'hff);
    rounds_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    rounds_sel = 2'd2;
    wait_done(120, "r8");
    rd_all("r8");

    // 12 rounds
    load();
    model(12);
    go(2'd1, 121, 1'b1);
    repeat (30) tick();
    wr_byte(0, 0, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(160, "r12");
    rd_all("r12");

    // abort at cycle 57, then restart to completion
    load();
    go(2'd2, 0, 1'b0);
    repeat (57) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_stat("abort_idle", 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) rd_word(i, st[i], $sformatf("abort_w%0d", i));
    model(20);
    go(2'd2, 201, 1'b1);
    wait_done(260, "after_abort");
    rd_all("after_abort");

    // write and start in the same IDLE cycle: byte 0 of b in column 0
    load();
    st[4][7:0] = 8'h55;
    model(8);
    done_q.push_back(81);
    write = 1'b1;
    addr = {2'd1, 2'd0, 2'd0};
    data_in = 8'h55;
    rounds_sel = 2'd0;
    start = 1'b1;
    tick();
    write = 1'b0;
    start = 1'b0;
    start_cyc = cyc;
    wait_done(120, "wr_start");
    rd_all("wr_start");

    // asynchronous reset in the middle of a 20-round run
    set_rfc();
    load();
    go(2'd2, 0, 1'b0);
    repeat (50) tick();
    #2 rst = 1'b1;
    chk_stat("rst_async", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_stat("rst_idle", 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) rd_word(i, (i < 4) ? AI[i] : 32'h0, $sformatf("rst_w%0d", i));

    check("pending_done", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
